spectrum_tx_ctrl: RTL and testbench

SPECTRUM_TX_CTRL -- requirements
Module: spectrum_tx_ctrl

---
 rtl/spectrum_pkg.sv | 29 ++
 rtl/spectrum_tx_ctrl_if.sv | 27 ++
 rtl/uart_tx_byte.sv | 56 +++++
 rtl/spectrum_tx_ctrl.sv | 156 +++++++++++++++
 tb/tb_spectrum_tx_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants, FSM encoding and byte helpers for the spectrum UART transmitter.
package spectrum_pkg;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

    localparam int DEF_N_SAMPLES    = 32'sd370;
    localparam int DEF_SAMPLE_W     = 32'sd10;
    localparam int DEF_CLKS_PER_BIT = 32'sd434;
    localparam int MAX_N_SAMPLES    = 32'sd65535;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        FIN  = 3'd5
    } tx_state_t;

    function automatic logic [7:0] hi_byte(input logic [15:0] v);
        return v[15:8];
    endfunction

    function automatic logic [7:0] lo_byte(input logic [15:0] v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/spectrum_tx_ctrl_if.sv
// Frame request / spectrum data / serial status bundle between source and transmitter.
interface spectrum_tx_ctrl_if #(
    parameter int N_SAMPLES = 370,
    parameter int SAMPLE_W  = 10
);
    logic                            start;
    logic [N_SAMPLES*SAMPLE_W-1:0]   spectrum_values;
    logic                            tx_pin;
    logic                            busy;
    logic                            done;

    modport master (
        output start,
        output spectrum_values,
        input  tx_pin,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  spectrum_values,
        output tx_pin,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser, LSB first; tx_busy rises the cycle after tx_load.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_pin
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic          busy_r;
    logic          pin_r;
    logic [8:0]    shift_r;
    logic [3:0]    bit_r;
    logic [CW-1:0] cnt_r;

    // Bit timer and shifter; bit_r counts bits already put on the line after the start bit.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            busy_r  <= 1'b0;
            pin_r   <= 1'b1;
            shift_r <= 9'h1FF;
            bit_r   <= 4'd0;
            cnt_r   <= '0;
        end else if (!busy_r) begin
            if (tx_load) begin
                busy_r  <= 1'b1;
                pin_r   <= 1'b0;
                shift_r <= {1'b1, tx_data};
                bit_r   <= 4'd0;
                cnt_r   <= '0;
            end else begin
                pin_r   <= 1'b1;
            end
        end else if (cnt_r == LAST_CLK) begin
            cnt_r <= '0;
            if (bit_r == 4'd9) begin
                busy_r <= 1'b0;
                pin_r  <= 1'b1;
            end else begin
                pin_r   <= shift_r[0];
                shift_r <= {1'b1, shift_r[8:1]};
                bit_r   <= bit_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tx_busy = busy_r;
    assign tx_pin  = pin_r;
endmodule

// File: rtl/spectrum_tx_ctrl.sv
// Frame sequencer: header, length, packed samples and XOR checksum fed byte by byte to uart_tx_byte.
module spectrum_tx_ctrl
    import spectrum_pkg::*;
#(
    parameter int N_SAMPLES    = DEF_N_SAMPLES,
    parameter int SAMPLE_W     = DEF_SAMPLE_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic               clk_50m,
    input  logic               rst,
    spectrum_tx_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [15:0]      N_LEN       = 16'(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_SAMPLES - 1);

    generate
        if (N_SAMPLES > MAX_N_SAMPLES || N_SAMPLES < 32'sd1) begin : g_bad_n_samples
            $error("spectrum_tx_ctrl: N_SAMPLES must be in 1..65535");
        end
    endgenerate

    tx_state_t          state_r, next_s;
    logic               start_q_r;
    logic               wait_r;
    logic               pos_r;
    logic               half_r;
    logic [CNT_W-1:0]   sample_cnt_r;
    logic [7:0]         csum_r;
    logic               busy_r;
    logic               done_r;

    logic               start_edge_s;
    logic               byte_done_s;
    logic               tx_load_s;
    logic [7:0]         tx_data_s;
    logic               tx_busy_s;
    logic               tx_pin_s;
    logic [SAMPLE_W-1:0] sample_s;
    logic [15:0]        sample_ext_s;

    assign start_edge_s = bus.start & ~start_q_r;
    // wait_r marks a byte handed to the engine; its busy dropping is the completion event.
    assign byte_done_s  = wait_r & ~tx_busy_s;
    assign sample_s     = bus.spectrum_values[sample_cnt_r * SAMPLE_W +: SAMPLE_W];
    assign sample_ext_s = 16'(sample_s);

    // State register.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next state, byte selection and load request.
    always_comb begin
        next_s    = state_r;
        tx_data_s = 8'h00;
        tx_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_edge_s) next_s = HDR;
                else              next_s = IDLE;
            end
            HDR: begin
                tx_data_s = pos_r ? HDR1 : HDR0;
                tx_load_s = ~wait_r & ~tx_busy_s;
                if (byte_done_s && pos_r) next_s = LEN;
                else                      next_s = HDR;
            end
            LEN: begin
                tx_data_s = pos_r ? lo_byte(N_LEN) : hi_byte(N_LEN);
                tx_load_s = ~wait_r & ~tx_busy_s;
                if (byte_done_s && pos_r) next_s = DATA;
                else                      next_s = LEN;
            end
            DATA: begin
                tx_data_s = half_r ? lo_byte(sample_ext_s) : hi_byte(sample_ext_s);
                tx_load_s = ~wait_r & ~tx_busy_s;
                if (byte_done_s && half_r && sample_cnt_r == LAST_SAMPLE) next_s = CSUM;
                else                                                       next_s = DATA;
            end
            CSUM: begin
                tx_data_s = csum_r;
                tx_load_s = ~wait_r & ~tx_busy_s;
                if (byte_done_s) next_s = FIN;
                else             next_s = CSUM;
            end
            FIN: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Byte bookkeeping, running checksum and registered status outputs.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            start_q_r    <= 1'b0;
            wait_r       <= 1'b0;
            pos_r        <= 1'b0;
            half_r       <= 1'b0;
            sample_cnt_r <= '0;
            csum_r       <= 8'h00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            start_q_r <= bus.start;
            busy_r    <= (next_s != IDLE);
            done_r    <= (next_s == FIN);
            if (state_r == IDLE) begin
                wait_r       <= 1'b0;
                pos_r        <= 1'b0;
                half_r       <= 1'b0;
                sample_cnt_r <= '0;
                csum_r       <= 8'h00;
            end else if (tx_load_s) begin
                wait_r <= 1'b1;
            end else if (byte_done_s) begin
                wait_r <= 1'b0;
                case (state_r)
                    HDR: pos_r <= ~pos_r;
                    LEN: begin
                        pos_r  <= ~pos_r;
                        csum_r <= csum_r ^ tx_data_s;
                    end
                    DATA: begin
                        csum_r <= csum_r ^ tx_data_s;
                        half_r <= ~half_r;
                        if (half_r) sample_cnt_r <= sample_cnt_r + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk_50m (clk_50m),
        .rst     (rst),
        .tx_load (tx_load_s),
        .tx_data (tx_data_s),
        .tx_busy (tx_busy_s),
        .tx_pin  (tx_pin_s)
    );

    assign bus.tx_pin = tx_pin_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_spectrum_tx_ctrl.sv
// Self-checking bench: a line-level UART decoder and frame model check spectrum_tx_ctrl every cycle.
module tb_spectrum_tx_ctrl;
    localparam int N   = 2;
    localparam int SW  = 10;
    localparam int CPB = 4;
    localparam int BITC = 10 * CPB;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_50m = ~clk_50m;

    spectrum_tx_ctrl_if #(.N_SAMPLES(N), .SAMPLE_W(SW)) bus ();

    spectrum_tx_ctrl #(
        .N_SAMPLES    (N),
        .SAMPLE_W     (SW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame model: byte idx of the frame built from plain arithmetic on the samples.
    function automatic logic [7:0] frame_byte(input logic [N*SW-1:0] v, input int idx);
        int s;
        int cs;
        if (idx == 0) return 8'hAA;
        if (idx == 1) return 8'h55;
        if (idx == 2) return 8'(N / 256);
        if (idx == 3) return 8'(N % 256);
        if (idx < 4 + 2 * N) begin
            s = int'(v[((idx - 4) / 2) * SW +: SW]);
            return (idx % 2 == 0) ? 8'(s / 256) : 8'(s % 256);
        end
        cs = (N / 256) ^ (N % 256);
        for (int k = 0; k < N; k++) begin
            s = int'(v[k * SW +: SW]);
            cs = cs ^ (s / 256) ^ (s % 256);
        end
        return 8'(cs);
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         frames_done = 0;
    bit         mon_en = 1'b0;
    bit         m_active = 1'b0;
    bit         prev_start = 1'b0;
    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    logic       samp [BITC];
    int         gap_cnt = 0;
    int         lat_cnt = 0;
    bit         lat_armed = 1'b0;

    task automatic finish_byte();
        bit ok;
        logic [7:0] b;
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < CPB; j++)
                if (samp[i * CPB + j] !== samp[i * CPB]) ok = 1'b0;
        check("bit_width_exact", 32'(ok), 32'd1);
        check("stop_bit_high", 32'(samp[9 * CPB]), 32'd1);
        for (int i = 0; i < 8; i++) b[i] = samp[(i + 1) * CPB];
        got_q.push_back(b);
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("byte_value", 32'(b), 32'(exp_q.pop_front()));
        dec_active = 1'b0;
        gap_cnt = 0;
    endtask

    // Per-cycle compare against the frame model; samples on the falling edge.
    always @(negedge clk_50m) begin
        bit was_active;
        if (mon_en) begin
            check("busy", 32'(bus.busy), 32'(m_active));
            if (!m_active) begin
                check("done_when_idle", 32'(bus.done), 32'd0);
                check("pin_idle_high", 32'(bus.tx_pin), 32'd1);
            end else if (bus.done) begin
                check("done_bytes_left", 32'(exp_q.size()), 32'd0);
                check("done_mid_byte", 32'(dec_active), 32'd0);
                frames_done++;
            end
            if (rst) begin
                dec_active = 1'b0;
            end else begin
                if (lat_armed) lat_cnt++;
                if (dec_active) begin
                    samp[dec_cnt] = bus.tx_pin;
                    dec_cnt++;
                    if (dec_cnt == BITC) finish_byte();
                end else if (bus.tx_pin == 1'b0) begin
                    if (lat_armed) begin
                        check("start_latency_le3", 32'((lat_cnt - 1) <= 3), 32'd1);
                        lat_armed = 1'b0;
                    end else begin
                        check("inter_byte_gap_le2", 32'(gap_cnt <= 2), 32'd1);
                    end
                    dec_active = 1'b1;
                    samp[0] = 1'b0;
                    dec_cnt = 1;
                end else begin
                    gap_cnt++;
                end
            end
            was_active = m_active;
            if (m_active && bus.done) m_active = 1'b0;
            if (rst) begin
                m_active   = 1'b0;
                prev_start = 1'b0;
                lat_armed  = 1'b0;
                exp_q.delete();
            end else begin
                if (bus.start && !prev_start && !was_active) begin
                    m_active  = 1'b1;
                    lat_armed = 1'b1;
                    lat_cnt   = 0;
                    for (int i = 0; i < 2 * N + 5; i++) exp_q.push_back(frame_byte(bus.spectrum_values, i));
                end
                prev_start = bus.start;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (bus.done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_log_lit(input string name, input logic [7:0] lit [9]);
        check({name, "_len"}, 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_q.size(); i++) check(name, 32'(got_q[i]), 32'(lit[i]));
    endtask

    task automatic check_log_model(input string name, input logic [N*SW-1:0] v);
        check({name, "_len"}, 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_q.size(); i++) check(name, 32'(got_q[i]), 32'(frame_byte(v, i)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]      nom [9];
        logic [7:0]      sat [9];
        logic [N*SW-1:0] v;
        int              f0;
        bit              ok;
        nom = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h02, 8'hB7, 8'h01, 8'h23, 8'h95};
        sat = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h02};

        bus.start = 1'b0;
        bus.spectrum_values = '0;
        rst = 1'b1;
        tick(3);
        check("reset_tx_pin", 32'(bus.tx_pin), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Model pinned against hand-computed frames.
        v = {10'h123, 10'h2B7};
        for (int i = 0; i < 9; i++) check("model_nominal", 32'(frame_byte(v, i)), 32'(nom[i]));
        v = {10'h3FF, 10'h3FF};
        for (int i = 0; i < 9; i++) check("model_saturated", 32'(frame_byte(v, i)), 32'(sat[i]));

        // Nominal frame.
        bus.spectrum_values = {10'h123, 10'h2B7};
        got_q.delete();
        f0 = frames_done;
        pulse_start();
        wait_done("nominal_done", 2000);
        tick(3);
        check_log_lit("nominal_bytes", nom);
        check("nominal_frames", 32'(frames_done - f0), 32'd1);

        // Start held high with extra pulses while busy.
        v = {SW'($urandom), SW'($urandom)};
        bus.spectrum_values = v;
        got_q.delete();
        f0 = frames_done;
        bus.start = 1'b1;
        tick(20);
        repeat (3) begin
            bus.start = 1'b0;
            tick(2);
            bus.start = 1'b1;
            tick(30);
        end
        wait_done("held_done", 2000);
        bus.start = 1'b0;
        tick(60);
        check("held_frames", 32'(frames_done - f0), 32'd1);
        check_log_model("held_bytes", v);

        // Reset in the middle of byte 5, then a full restart.
        v = {SW'($urandom), SW'($urandom)};
        bus.spectrum_values = v;
        got_q.delete();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick(1);
            if (got_q.size() >= 5) ok = 1'b1;
        end
        check("reached_byte5", 32'(ok), 32'd1);
        tick(12);
        rst = 1'b1;
        tick(1);
        check("abort_tx_pin", 32'(bus.tx_pin), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick(3);
        got_q.delete();
        pulse_start();
        wait_done("restart_done", 2000);
        tick(3);
        check_log_model("restart_bytes", v);

        // Reset and start in the same cycle: reset wins, no frame.
        f0 = frames_done;
        bus.start = 1'b1;
        rst = 1'b1;
        tick(1);
        check("rst_prio_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        tick(10);
        check("rst_prio_frames", 32'(frames_done - f0), 32'd0);
        check("rst_prio_idle", 32'(bus.busy), 32'd0);

        // Saturated samples; a start edge in the done cycle is ignored.
        bus.spectrum_values = {10'h3FF, 10'h3FF};
        got_q.delete();
        f0 = frames_done;
        pulse_start();
        wait_done("sat_done", 2000);
        bus.start = 1'b1;
        tick(3);
        bus.start = 1'b0;
        tick(100);
        check_log_lit("sat_bytes", sat);
        check("sat_no_second_frame", 32'(frames_done - f0), 32'd1);
        check("sat_idle_after", 32'(bus.busy), 32'd0);

        // Randomised frames with random start widths and idle times.
        for (int r = 0; r < 6; r++) begin
            v = {SW'($urandom), SW'($urandom)};
            bus.spectrum_values = v;
            got_q.delete();
            tick($urandom_range(1, 8));
            bus.start = 1'b1;
            tick($urandom_range(1, 5));
            bus.start = 1'b0;
            if (r % 2 == 1) begin
                tick($urandom_range(10, 100));
                pulse_start();
            end
            wait_done("rand_done", 2000);
            tick(3);
            check_log_model("rand_bytes", v);
        end

        tick(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
